// File: rtl/fruit_controller.sv
// Four-slot fruit spawner: each slot hangs, falls, despawns at the floor or is eaten on collision.
// Optional macro FRUIT_BLINK_EN adds a blinking EATEN phase; without it an eaten fruit vanishes at once.
module fruit_controller #(
  parameter logic signed [10:0] HANG_Y      = 11'sd64,
  parameter logic signed [10:0] FLOOR_Y     = 11'sd448,
  parameter logic signed [10:0] FALL_STEP   = 11'sd4,
  parameter logic        [7:0]  HANG_FRAMES = 8'd120,
  parameter logic        [7:0]  EAT_FRAMES  = 8'd16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               spawnReq,
  input  logic signed [10:0] spawnX,
  input  logic        [1:0]  spawnChoice,
  input  logic        [3:0]  collision,
  output logic               spawnAck,
  output logic               full,
  output logic        [43:0] topLeftX,
  output logic        [43:0] topLeftY,
  output logic        [7:0]  fruitChoice,
  output logic        [3:0]  drawFruit,
  output logic               scorePulse,
  output logic        [8:0]  scoreValue
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HANG  = 2'd1;
  localparam logic [1:0] ST_FALL  = 2'd2;
  localparam logic [1:0] ST_EATEN = 2'd3;

  logic        [1:0]  state_q  [4];
  logic        [1:0]  state_d  [4];
  logic signed [10:0] x_q      [4];
  logic signed [10:0] x_d      [4];
  logic signed [10:0] y_q      [4];
  logic signed [10:0] y_d      [4];
  logic signed [10:0] y_step   [4];
  logic        [1:0]  choice_q [4];
  logic        [1:0]  choice_d [4];
  logic        [7:0]  cnt_q    [4];
  logic        [7:0]  cnt_d    [4];

  logic        spawn_ok;
  logic [1:0]  spawn_idx;
  logic        ack_q, ack_d;
  logic        full_q, full_d;
  logic        pulse_q, pulse_d;
  logic [8:0]  value_q, value_d;

  // Base value 10/20/30/40 by choice, doubled when caught mid-fall.
  function automatic logic [8:0] fruit_value(input logic [1:0] c, input logic dbl);
    logic [8:0] v;
    v = ({7'd0, c} + 9'd1) * 9'd10;
    if (dbl) v = v << 1;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) y_step[i] = y_q[i] + FALL_STEP;
  end

  // Descending scan so the lowest-index IDLE slot is the one left selected.
  always_comb begin
    spawn_ok  = 1'b0;
    spawn_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (state_q[i] == ST_IDLE) begin
        spawn_ok  = 1'b1;
        spawn_idx = i[1:0];
      end
    end
  end

  always_comb begin
    ack_d   = spawnReq && spawn_ok;
    pulse_d = 1'b0;
    value_d = 9'd0;
    for (int i = 0; i < 4; i++) begin
      state_d[i]  = state_q[i];
      x_d[i]      = x_q[i];
      y_d[i]      = y_q[i];
      choice_d[i] = choice_q[i];
      cnt_d[i]    = cnt_q[i];
      if (collision[i] && (state_q[i] == ST_HANG || state_q[i] == ST_FALL)) begin
        pulse_d  = 1'b1;
        value_d  = value_d + fruit_value(choice_q[i], state_q[i] == ST_FALL);
        cnt_d[i] = 8'd0;
`ifdef FRUIT_BLINK_EN
        state_d[i] = ST_EATEN;
`else
        state_d[i] = ST_IDLE;
`endif
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (ack_d && spawn_idx == i[1:0]) begin
              state_d[i]  = ST_HANG;
              x_d[i]      = spawnX;
              y_d[i]      = HANG_Y;
              choice_d[i] = spawnChoice;
              cnt_d[i]    = 8'd0;
            end
          end
          ST_HANG: begin
            if (startOfFrame) begin
              if (cnt_q[i] == HANG_FRAMES - 8'd1) begin
                state_d[i] = ST_FALL;
                cnt_d[i]   = 8'd0;
              end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
              end
            end
          end
          ST_FALL: begin
            if (startOfFrame) begin
              if (y_step[i] >= FLOOR_Y) state_d[i] = ST_IDLE;
              else                      y_d[i]     = y_step[i];
            end
          end
          default: begin
            if (startOfFrame) begin
              if (cnt_q[i] == EAT_FRAMES - 8'd1) state_d[i] = ST_IDLE;
              else                               cnt_d[i]   = cnt_q[i] + 8'd1;
            end
          end
        endcase
      end
    end
    full_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (state_d[i] == ST_IDLE) full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= ST_IDLE;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
        choice_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ack_q   <= 1'b0;
      full_q  <= 1'b0;
      pulse_q <= 1'b0;
      value_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= state_d[i];
        x_q[i]      <= x_d[i];
        y_q[i]      <= y_d[i];
        choice_q[i] <= choice_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      ack_q   <= ack_d;
      full_q  <= full_d;
      pulse_q <= pulse_d;
      value_q <= value_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign topLeftX[11*g +: 11]  = x_q[g];
    assign topLeftY[11*g +: 11]  = y_q[g];
    assign fruitChoice[2*g +: 2] = choice_q[g];
`ifdef FRUIT_BLINK_EN
    assign drawFruit[g] = (state_q[g] == ST_HANG) || (state_q[g] == ST_FALL) ||
                          ((state_q[g] == ST_EATEN) && !cnt_q[g][1]);
`else
    assign drawFruit[g] = (state_q[g] == ST_HANG) || (state_q[g] == ST_FALL);
`endif
  end

  assign spawnAck   = ack_q;
  assign full       = full_q;
  assign scorePulse = pulse_q;
  assign scoreValue = value_q;

endmodule

// File: doc/fruit_controller.md
FRUIT_CONTROLLER -- requirements
Module: fruit_controller

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- HANG_Y, 11'd64, Y coordinate at which a spawned fruit hangs.
- FLOOR_Y, 11'd448, Y threshold at which a falling fruit despawns.
- FALL_STEP, 11'd4, pixels added to Y per frame while falling.
- HANG_FRAMES, 8'd120, frames a fruit hangs before it falls.
- EAT_FRAMES, 8'd16, frames an eaten fruit blinks.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- startOfFrame, in, 1, one-cycle pulse per VGA frame.
- spawnReq, in, 1, request a new fruit.
- spawnX, in, 11, signed topLeftX for the new fruit.
- spawnChoice, in, 2, fruit bitmap index for the new fruit.
- collision, in, 4, per-slot player/fruit overlap; bit i refers to slot i.
- spawnAck, out, 1, one-cycle pulse: the request was accepted.
- full, out, 1, no slot is IDLE.
- topLeftX, out, 44, signed X of slot i in bits [11i+10:11i].
- topLeftY, out, 44, signed Y of slot i in bits [11i+10:11i].
- fruitChoice, out, 8, choice of slot i in bits [2i+1:2i].
- drawFruit, out, 4, slot i is visible.
- scorePulse, out, 1, one-cycle pulse: at least one fruit was eaten this cycle.
- scoreValue, out, 9, points awarded this cycle; valid while scorePulse is high.

Function
REQ-003 Each of the 4 slots shall hold a state in {IDLE, HANG, FALL, EATEN}, plus X, Y, choice and an 8-bit frame counter.
REQ-004 On spawnReq with at least one slot IDLE, the lowest-index IDLE slot shall enter HANG on the next edge with X=spawnX, Y=HANG_Y, counter=0; spawnAck shall be high for exactly that cycle.
REQ-005 On spawnReq with no slot IDLE, the request shall be dropped with no spawnAck; spawnReq held high shall spawn one fruit per cycle while slots remain.
REQ-006 In HANG, each startOfFrame shall increment the counter; at counter==HANG_FRAMES-1 the slot shall enter FALL with counter=0.
REQ-007 In FALL, each startOfFrame shall set Y=Y+FALL_STEP using 11-bit signed arithmetic; if the new Y is >= FLOOR_Y, the slot shall enter IDLE instead (despawn, no score).
REQ-008 collision[i] high while slot i is in HANG or FALL shall move slot i to EATEN (counter=0) on the next edge; collision shall take priority over the same-cycle frame step or despawn.
REQ-009 collision[i] shall be ignored while slot i is in IDLE or EATEN.
REQ-010 Base fruit value shall be 10/20/30/40 for choice 0/1/2/3; a fruit eaten in FALL shall score double.
REQ-011 scoreValue shall be the sum of the values of all slots entering EATEN on that edge (maximum 320); scorePulse and scoreValue shall be registered and aligned with the state change.
REQ-012 scoreValue shall be 0 whenever scorePulse is low.
REQ-013 In EATEN, each startOfFrame shall increment the counter; at counter==EAT_FRAMES-1 the slot shall enter IDLE.
REQ-014 drawFruit[i] shall be 1 in HANG and FALL, 0 in IDLE, and per REQ-019 in EATEN.
REQ-015 Position and choice outputs of an IDLE slot shall hold their last values.
REQ-016 full shall equal "no slot is IDLE", registered.
REQ-017 A slot may be re-spawned in the same cycle it becomes visible as IDLE on the outputs.

Reset
REQ-018 reset high at a rising edge shall force, on that edge:
- all slots to IDLE, all counters to 0;
- topLeftX, topLeftY, fruitChoice, drawFruit, spawnAck, scorePulse, scoreValue to 0;
- full to 0.
Reset shall override any in-flight spawn, collision or frame step.

Configuration
REQ-019 Macro FRUIT_BLINK_EN:
- Defined: drawFruit[i] in EATEN shall equal counter[1] inverted (blinks every 2 frames).
- Undefined: the EATEN state shall not exist; a collision moves the slot straight to IDLE, with drawFruit[i]=0 on the next cycle; scoring is unchanged.

Verification
REQ-020 The bench shall cover these directed scenarios:
- Spawn at X=100, choice 2 -> slot0 HANG, Y=64, spawnAck for 1 cycle; after 120 frames, Y steps by 4 each frame; despawns once Y>=448.
- 5 spawnReq in consecutive cycles -> slots 0-3 filled, full=1, fifth request gives no spawnAck.
- collision=4'b0101 with slot0 in HANG (choice 0) and slot2 in FALL (choice 3) -> scorePulse=1, scoreValue=10+80=90.
- With FRUIT_BLINK_EN: eaten slot blinks and returns to IDLE after 16 frames; without it: drawFruit drops next cycle.
- Collision on the same edge as the despawn step -> EATEN with doubled score; no silent despawn.
- reset mid-FALL and mid-EATEN -> all outputs 0 on the next cycle; a spawn immediately afterwards uses slot0.
